// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the instruction fetch stage: datapath width, the
//   NOP encoding used to blank IR, the fetch request FSM state type and the
//   prefetch FIFO entry layout.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  // Request FSM: IDLE = nothing outstanding, WAIT = request outstanding,
  // DROP = request outstanding whose response belongs to a squashed path.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // One buffered instruction: its address plus one, and the word itself.
  typedef struct packed {
    logic [WORD_W-1:0] pc_m1;
    logic [WORD_W-1:0] instr;
  } fifo_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
//   Instruction memory read channel (req/ack handshake, one outstanding
//   request).
//   master : fetch unit  -> drives IMEM_REQ / IMEM_ADDR, samples ACK / RDATA
//   slave  : memory      -> drives IMEM_ACK / IMEM_RDATA
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
  import cpu_pkg::*;

  logic              IMEM_REQ;
  logic [WORD_W-1:0] IMEM_ADDR;
  logic              IMEM_ACK;
  logic [WORD_W-1:0] IMEM_RDATA;

  modport master (
    output IMEM_REQ,
    output IMEM_ADDR,
    input  IMEM_ACK,
    input  IMEM_RDATA
  );

  modport slave (
    input  IMEM_REQ,
    input  IMEM_ADDR,
    output IMEM_ACK,
    output IMEM_RDATA
  );

endinterface

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Prefetch buffer, DEPTH entries of fifo_entry_t (power-of-two DEPTH >= 2).
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     push, wdata   write one entry
//     pop, rdata    consume the head entry (rdata is the current head)
//     flush         discard everything; wins over push/pop
//     count         number of stored entries (0..DEPTH)
//     full, empty   status flags
//   Push and pop may coincide when full (pop frees the slot) or when empty
//   (the pop is ignored and the push lands).
// ---------------------------------------------------------------------------
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fifo_entry_t            wdata,
  input  logic                   pop,
  output fifo_entry_t            rdata,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap for free because DEPTH is a power of two.
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count/pointers say
  // which entries are meaningful, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction fetch stage with prefetch buffer. Owns the fetch PC, issues
//   word reads over a req/ack channel (one outstanding), buffers responses
//   and presents IR / PC_M1 / VALID to decode with stall and branch flush.
//   Ports:
//     CLOCK, RESET          clock, synchronous active-high reset
//     BR_TAKEN, BR_TARGET   one-cycle redirect to a new word address
//     STALL                 decode holds the current IR/PC_M1/VALID
//     imem (master)         IMEM_REQ/IMEM_ADDR out, IMEM_ACK/IMEM_RDATA in
//     IR, PC_M1, VALID      instruction, its address + 1, and its validity
// ---------------------------------------------------------------------------
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       DEPTH    = 2,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  BR_TAKEN,
  input  logic [WORD_W-1:0]     BR_TARGET,
  input  logic                  STALL,
  if_fetch_unit_if.master       imem,
  output logic [WORD_W-1:0]     IR,
  output logic [WORD_W-1:0]     PC_M1,
  output logic                  VALID
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] addr_q, addr_d;     // address presented on IMEM_ADDR
  logic [WORD_W-1:0] tgt_q, tgt_d;       // redirect parked while in DROP
  logic [WORD_W-1:0] ir_q, ir_d;
  logic [WORD_W-1:0] pc_m1_q, pc_m1_d;
  logic              valid_q, valid_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  fifo_entry_t       resp_entry, head_entry;
  logic              resp_ok, out_free, bypass, space;
  logic [CW1-1:0]    cnt_after;

  // A response is usable only for a live request and not in a branch cycle.
  assign resp_ok   = (state_q == ST_WAIT) && imem.IMEM_ACK && !BR_TAKEN;
  assign out_free  = !valid_q || !STALL;
  assign bypass    = resp_ok && fifo_empty && out_free;
  assign fifo_pop  = out_free && !fifo_empty && !BR_TAKEN;
  assign fifo_push = resp_ok && !bypass;

  assign resp_entry = '{pc_m1: addr_q + 32'd1, instr: imem.IMEM_RDATA};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLOCK),
    .rst   (RESET),
    .push  (fifo_push),
    .wdata (resp_entry),
    .pop   (fifo_pop),
    .rdata (head_entry),
    .flush (BR_TAKEN),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Occupancy after this edge's push/pop; a new request is only allowed if
  // its response is guaranteed a slot.
  always_comb begin
    cnt_after = {1'b0, fifo_count} + CW1'(fifo_push) - CW1'(fifo_pop);
    space     = (cnt_after < CW1'(DEPTH));
  end

  // Request FSM and fetch address.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tgt_d   = tgt_q;
    if (BR_TAKEN) begin
      if ((state_q != ST_IDLE) && !imem.IMEM_ACK) begin
        // Old request still in flight: keep IMEM_ADDR stable, park target.
        state_d = ST_DROP;
        tgt_d   = BR_TARGET;
      end else begin
        // Nothing outstanding after this edge; FIFO is flushed so a slot
        // is free and the target can be requested immediately.
        state_d = ST_WAIT;
        addr_d  = BR_TARGET;
      end
    end else begin
      case (state_q)
        ST_IDLE: if (space) state_d = ST_WAIT;
        ST_WAIT: begin
          if (imem.IMEM_ACK) begin
            addr_d  = addr_q + 32'd1;
            state_d = space ? ST_WAIT : ST_IDLE;
          end
        end
        ST_DROP: begin
          if (imem.IMEM_ACK) begin
            addr_d  = tgt_q;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output registers: branch blanks them, otherwise advance whenever decode
  // can take a new word, preferring the FIFO head to keep program order.
  always_comb begin
    ir_d    = ir_q;
    pc_m1_d = pc_m1_q;
    valid_d = valid_q;
    if (BR_TAKEN) begin
      ir_d    = NOP_INSTR;
      valid_d = 1'b0;
    end else if (out_free) begin
      if (!fifo_empty) begin
        ir_d    = head_entry.instr;
        pc_m1_d = head_entry.pc_m1;
        valid_d = 1'b1;
      end else if (bypass) begin
        ir_d    = resp_entry.instr;
        pc_m1_d = resp_entry.pc_m1;
        valid_d = 1'b1;
      end else begin
        ir_d    = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      addr_q  <= RESET_PC;
      tgt_q   <= RESET_PC;
      ir_q    <= NOP_INSTR;
      pc_m1_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
      ir_q    <= ir_d;
      pc_m1_q <= pc_m1_d;
      valid_q <= valid_d;
    end
  end

  assign imem.IMEM_REQ  = (state_q != ST_IDLE);
  assign imem.IMEM_ADDR = addr_q;
  assign IR             = ir_q;
  assign PC_M1          = pc_m1_q;
  assign VALID          = valid_q;

  a_no_push_when_full: assert property (
    @(posedge CLOCK) disable iff (RESET) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  import cpu_pkg::*;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        BR_TAKEN;
  logic [31:0] BR_TARGET;
  logic        STALL;
  logic [31:0] IR;
  logic [31:0] PC_M1;
  logic        VALID;

  // Memory model: zero-wait (ACK follows REQ, RDATA = addr*4) or manual.
  logic        zw;
  logic        ack_man;
  logic [31:0] rdata_man;

  int checks = 0;
  int errors = 0;

  if_fetch_unit_if mem_if ();

  assign mem_if.IMEM_ACK   = zw ? mem_if.IMEM_REQ : ack_man;
  assign mem_if.IMEM_RDATA = zw ? (mem_if.IMEM_ADDR << 2) : rdata_man;

  if_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0)) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .BR_TAKEN  (BR_TAKEN),
    .BR_TARGET (BR_TARGET),
    .STALL     (STALL),
    .imem      (mem_if),
    .IR        (IR),
    .PC_M1     (PC_M1),
    .VALID     (VALID)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset(input logic zero_wait);
    zw = zero_wait; ack_man = 1'b0; rdata_man = 32'h0;
    BR_TAKEN = 1'b0; BR_TARGET = 32'h0; STALL = 1'b0; RESET = 1'b1;
    repeat (3) step();
    RESET = 1'b0;
  endtask

  task automatic branch_to(input logic [31:0] tgt);
    BR_TAKEN = 1'b1; BR_TARGET = tgt;
    step();
    BR_TAKEN = 1'b0;
  endtask

  task automatic test_reset();
    zw = 1'b1; ack_man = 1'b0; rdata_man = 32'h0;
    BR_TAKEN = 1'b0; BR_TARGET = 32'h0; STALL = 1'b0; RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (mem_if.IMEM_REQ !== 1'b0) begin errors++; $display("FAIL reset_req[%0d] got=%b exp=0", i, mem_if.IMEM_REQ); end
      checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got=%b exp=0", i, VALID); end
    end
    RESET = 1'b0;
    checks++; if (mem_if.IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_if.IMEM_ADDR); end
    checks++; if (IR !== 32'h0 || PC_M1 !== 32'h0) begin errors++; $display("FAIL reset_out got=%h/%h exp=0/0", IR, PC_M1); end
    step();
    checks++; if (mem_if.IMEM_REQ !== 1'b1 || mem_if.IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL first_req got=%b/%h exp=1/0", mem_if.IMEM_REQ, mem_if.IMEM_ADDR); end
    step();
    checks++; if (VALID !== 1'b1 || PC_M1 !== 32'h1 || IR !== 32'h0) begin errors++; $display("FAIL first_valid got=%b/%h/%h exp=1/1/0", VALID, PC_M1, IR); end
  endtask

  task automatic test_streaming();
    do_reset(1'b1);
    step();
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (VALID !== 1'b1 || IR !== 32'((k - 1) * 4) || PC_M1 !== 32'(k) || mem_if.IMEM_REQ !== 1'b1) begin
        errors++;
        $display("FAIL stream[%0d] got v=%b ir=%h pc=%h req=%b exp v=1 ir=%h pc=%h req=1",
                 k, VALID, IR, PC_M1, mem_if.IMEM_REQ, 32'((k - 1) * 4), 32'(k));
      end
    end
  endtask

  task automatic test_stall_fill();
    logic [5:0] req_exp;
    req_exp = 6'b000011;  // bit i = expected IMEM_REQ after stalled step i+1
    do_reset(1'b1);
    branch_to(32'h10);
    STALL = 1'b1;
    checks++; if (mem_if.IMEM_ADDR !== 32'h10) begin errors++; $display("FAIL stall_addr got=%h exp=10", mem_if.IMEM_ADDR); end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (mem_if.IMEM_REQ !== req_exp[i] || VALID !== 1'b1 || IR !== 32'h40 || PC_M1 !== 32'h11) begin
        errors++;
        $display("FAIL stall_hold[%0d] got req=%b v=%b ir=%h pc=%h exp req=%b v=1 ir=40 pc=11",
                 i, mem_if.IMEM_REQ, VALID, IR, PC_M1, req_exp[i]);
      end
      if (i == 2) begin
        checks++; if (dut.fifo_count !== 2'd2) begin errors++; $display("FAIL stall_count got=%0d exp=2", dut.fifo_count); end
      end
    end
    STALL = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      step();
      checks++;
      if (VALID !== 1'b1 || IR !== 32'((32'h10 + j) * 4) || PC_M1 !== 32'(32'h11 + j)) begin
        errors++;
        $display("FAIL stall_release[%0d] got v=%b ir=%h pc=%h exp v=1 ir=%h pc=%h",
                 j, VALID, IR, PC_M1, 32'((32'h10 + j) * 4), 32'(32'h11 + j));
      end
    end
  endtask

  task automatic test_branch_late_ack();
    do_reset(1'b0);
    branch_to(32'h5);
    checks++; if (mem_if.IMEM_REQ !== 1'b1 || mem_if.IMEM_ADDR !== 32'h5) begin errors++; $display("FAIL late_req5 got=%b/%h exp=1/5", mem_if.IMEM_REQ, mem_if.IMEM_ADDR); end
    step();
    branch_to(32'h80);
    checks++; if (dut.state_q !== ST_DROP) begin errors++; $display("FAIL late_drop got=%0d exp=%0d", dut.state_q, ST_DROP); end
    checks++; if (mem_if.IMEM_REQ !== 1'b1 || mem_if.IMEM_ADDR !== 32'h5 || VALID !== 1'b0) begin errors++; $display("FAIL late_hold got=%b/%h/%b exp=1/5/0", mem_if.IMEM_REQ, mem_if.IMEM_ADDR, VALID); end
    ack_man = 1'b1; rdata_man = 32'hDEAD_0005;
    step();
    ack_man = 1'b0;
    checks++; if (mem_if.IMEM_REQ !== 1'b0 || VALID !== 1'b0) begin errors++; $display("FAIL late_idle got=%b/%b exp=0/0", mem_if.IMEM_REQ, VALID); end
    step();
    checks++; if (mem_if.IMEM_REQ !== 1'b1 || mem_if.IMEM_ADDR !== 32'h80 || VALID !== 1'b0) begin errors++; $display("FAIL late_req80 got=%b/%h/%b exp=1/80/0", mem_if.IMEM_REQ, mem_if.IMEM_ADDR, VALID); end
    step();
    step();
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL late_wait got=%b exp=0", VALID); end
    ack_man = 1'b1; rdata_man = 32'h1234_0080;
    step();
    ack_man = 1'b0;
    checks++; if (VALID !== 1'b1 || PC_M1 !== 32'h81 || IR !== 32'h1234_0080) begin errors++; $display("FAIL late_target got=%b/%h/%h exp=1/81/12340080", VALID, PC_M1, IR); end
  endtask

  task automatic test_branch_with_ack();
    do_reset(1'b0);
    branch_to(32'h7);
    ack_man = 1'b1; rdata_man = 32'h0777_0007;
    branch_to(32'h40);
    ack_man = 1'b0;
    checks++; if (VALID !== 1'b0 || IR !== 32'h0) begin errors++; $display("FAIL coinc_valid got=%b/%h exp=0/0", VALID, IR); end
    checks++; if (mem_if.IMEM_REQ !== 1'b1 || mem_if.IMEM_ADDR !== 32'h40) begin errors++; $display("FAIL coinc_addr got=%b/%h exp=1/40", mem_if.IMEM_REQ, mem_if.IMEM_ADDR); end
    ack_man = 1'b1; rdata_man = 32'h0000_4040;
    step();
    ack_man = 1'b0;
    checks++; if (VALID !== 1'b1 || IR !== 32'h4040 || PC_M1 !== 32'h41) begin errors++; $display("FAIL coinc_target got=%b/%h/%h exp=1/4040/41", VALID, IR, PC_M1); end
  endtask

  task automatic test_reset_wrap();
    do_reset(1'b1);
    branch_to(32'hFFFF_FFFF);
    checks++; if (mem_if.IMEM_ADDR !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_addr got=%h exp=ffffffff", mem_if.IMEM_ADDR); end
    step();
    checks++; if (VALID !== 1'b1 || IR !== 32'hFFFF_FFFC || PC_M1 !== 32'h0) begin errors++; $display("FAIL wrap_out got=%b/%h/%h exp=1/fffffffc/0", VALID, IR, PC_M1); end
    checks++; if (mem_if.IMEM_REQ !== 1'b1 || mem_if.IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL wrap_next got=%b/%h exp=1/0", mem_if.IMEM_REQ, mem_if.IMEM_ADDR); end
    zw = 1'b0; ack_man = 1'b0;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    checks++; if (mem_if.IMEM_REQ !== 1'b0 || VALID !== 1'b0) begin errors++; $display("FAIL midreset got=%b/%b exp=0/0", mem_if.IMEM_REQ, VALID); end
    ack_man = 1'b1; rdata_man = 32'hBAD0_0BAD;
    step();
    ack_man = 1'b0;
    checks++; if (VALID !== 1'b0 || mem_if.IMEM_REQ !== 1'b1 || mem_if.IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL late_ack_ignored got=%b/%b/%h exp=0/1/0", VALID, mem_if.IMEM_REQ, mem_if.IMEM_ADDR); end
    step();
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL late_ack_after got=%b exp=0", VALID); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_fill();
    test_branch_late_ack();
    test_branch_with_ack();
    test_reset_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
